// File: rtl/wvb_readout_arbiter_if.sv
// Output stream of the waveform readout arbiter: one word per valid/ready handshake,
// plus the header and source channel of the event the word belongs to.
interface wvb_readout_arbiter_if #(
  parameter int unsigned P_DATA_WIDTH = 22,
  parameter int unsigned P_HDR_WIDTH  = 80,
  parameter int unsigned P_CHAN_WIDTH = 2
);
  logic                    valid;
  logic                    ready;
  logic [P_DATA_WIDTH-1:0] data;
  logic [P_HDR_WIDTH-1:0]  hdr;
  logic [P_CHAN_WIDTH-1:0] chan;
  logic                    sop;
  logic                    eop;

  modport master (output valid, data, hdr, chan, sop, eop, input ready);
  modport slave  (input valid, data, hdr, chan, sop, eop, output ready);
endinterface

// File: rtl/wvb_readout_arbiter.sv
// Round-robin readout controller: grants one waveform channel at a time, pops its header,
// streams its words until EOE (or the overlength guard) and then signals rddone.
module wvb_readout_arbiter #(
  parameter int unsigned P_N_CHAN     = 4,
  parameter int unsigned P_CHAN_WIDTH = 2,
  parameter int unsigned P_DATA_WIDTH = 22,
  parameter int unsigned P_HDR_WIDTH  = 80,
  parameter int unsigned P_MAX_WORDS  = 4096
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic [P_N_CHAN-1:0]              chan_mask,
  input  logic [P_N_CHAN-1:0]              hdr_empty,
  input  logic [P_N_CHAN*P_HDR_WIDTH-1:0]  hdr_data,
  output logic [P_N_CHAN-1:0]              hdr_rdreq,
  input  logic [P_N_CHAN*P_DATA_WIDTH-1:0] wvb_data,
  output logic [P_N_CHAN-1:0]              wvb_rdreq,
  output logic [P_N_CHAN-1:0]              wvb_rddone,
  wvb_readout_arbiter_if.master            out,
  output logic                             busy,
  output logic                             err_overlen
);
  localparam int unsigned CntW = $clog2(P_MAX_WORDS + 1);

  // StPop: header pop visible; StRd: word read visible; StCap: returned word is valid.
  typedef enum logic [2:0] {StIdle, StPop, StRd, StCap, StOut, StDone} state_e;

  state_e                  state_q, state_d;
  logic [P_CHAN_WIDTH-1:0] rr_ptr_q, chan_q, rr_next;
  logic [P_HDR_WIDTH-1:0]  hdr_q;
  logic [P_DATA_WIDTH-1:0] data_q, cur_word;
  logic                    valid_q, sop_q, eop_q, first_q, err_q;
  logic [CntW-1:0]         cnt_q, cnt_inc;
  logic [P_N_CHAN-1:0]     hdr_rdreq_q, hdr_rdreq_d;
  logic [P_N_CHAN-1:0]     wvb_rdreq_q, wvb_rdreq_d;
  logic [P_N_CHAN-1:0]     rddone_q, rddone_d;
  logic [P_N_CHAN-1:0]     req;
  logic                    gnt_found, cur_eoe, hit_max;
  logic [P_CHAN_WIDTH-1:0] gnt_idx, scan_idx;

  assign req      = ~hdr_empty & chan_mask;
  assign cur_word = wvb_data[int'(chan_q)*P_DATA_WIDTH +: P_DATA_WIDTH];
  assign cur_eoe  = cur_word[P_DATA_WIDTH-1];
  assign cnt_inc  = cnt_q + CntW'(1);
  assign hit_max  = (cnt_inc == CntW'(P_MAX_WORDS));
  assign rr_next  = (chan_q == P_CHAN_WIDTH'(P_N_CHAN - 1)) ? '0 : chan_q + P_CHAN_WIDTH'(1);

  // First eligible channel at or after rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < P_N_CHAN; k++) begin
      scan_idx = P_CHAN_WIDTH'((int'(rr_ptr_q) + int'(k)) % int'(P_N_CHAN));
      if (!gnt_found && req[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en && gnt_found) state_d = StPop;
      StPop:   state_d = StRd;
      StRd:    state_d = StCap;
      StCap:   state_d = StOut;
      StOut:   if (out.ready) state_d = eop_q ? StDone : StRd;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Strobes are registered from the next state so each lasts exactly one cycle.
  always_comb begin
    hdr_rdreq_d = '0;
    wvb_rdreq_d = '0;
    rddone_d    = '0;
    if (state_d == StPop)  hdr_rdreq_d[gnt_idx] = 1'b1;
    if (state_d == StRd)   wvb_rdreq_d[chan_q]  = 1'b1;
    if (state_d == StDone) rddone_d[chan_q]     = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_rdreq_q <= '0;
      wvb_rdreq_q <= '0;
      rddone_q    <= '0;
      rr_ptr_q    <= '0;
      chan_q      <= '0;
      hdr_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      first_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      hdr_rdreq_q <= hdr_rdreq_d;
      wvb_rdreq_q <= wvb_rdreq_d;
      rddone_q    <= rddone_d;
      if (state_q == StIdle && state_d == StPop) begin
        chan_q  <= gnt_idx;
        hdr_q   <= hdr_data[int'(gnt_idx)*P_HDR_WIDTH +: P_HDR_WIDTH];
        first_q <= 1'b1;
      end
      if (state_q == StCap) begin
        data_q  <= cur_word;
        valid_q <= 1'b1;
        sop_q   <= first_q;
        first_q <= 1'b0;
        cnt_q   <= cnt_inc;
        eop_q   <= cur_eoe | hit_max;
        if (hit_max && !cur_eoe) err_q <= 1'b1;
      end
      if (state_q == StOut && out.ready) valid_q <= 1'b0;
      if (state_q == StDone) begin
        rr_ptr_q <= rr_next;
        cnt_q    <= '0;
      end
    end
  end

  assign hdr_rdreq   = hdr_rdreq_q;
  assign wvb_rdreq   = wvb_rdreq_q;
  assign wvb_rddone  = rddone_q;
  assign out.valid   = valid_q;
  assign out.data    = data_q;
  assign out.hdr     = hdr_q;
  assign out.chan    = chan_q;
  assign out.sop     = sop_q;
  assign out.eop     = eop_q;
  assign busy        = (state_q != StIdle);
  assign err_overlen = err_q;
endmodule

// File: tb/tb_wvb_readout_arbiter.sv
// Directed bench for wvb_readout_arbiter: behavioural per-channel buffers, a negedge
// monitor logging grants/words/rddone, and one task per scenario.
module tb_wvb_readout_arbiter;
  localparam int unsigned N = 4, CW = 2, DW = 22, HW = 80, MAXW = 8, DEPTH = 64;

  logic              clk = 1'b0;
  logic              rst_n, en, flush;
  logic [N-1:0]      chan_mask, hdr_empty, hdr_rdreq, wvb_rdreq, wvb_rddone;
  logic [N*HW-1:0]   hdr_data;
  logic [N*DW-1:0]   wvb_data;
  logic              busy, err_overlen;

  wvb_readout_arbiter_if #(.P_DATA_WIDTH(DW), .P_HDR_WIDTH(HW), .P_CHAN_WIDTH(CW)) out_if ();

  wvb_readout_arbiter #(
    .P_N_CHAN(N), .P_CHAN_WIDTH(CW), .P_DATA_WIDTH(DW), .P_HDR_WIDTH(HW), .P_MAX_WORDS(MAXW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .chan_mask(chan_mask), .hdr_empty(hdr_empty),
    .hdr_data(hdr_data), .hdr_rdreq(hdr_rdreq), .wvb_data(wvb_data), .wvb_rdreq(wvb_rdreq),
    .wvb_rddone(wvb_rddone), .out(out_if), .busy(busy), .err_overlen(err_overlen)
  );

  always #5 clk = ~clk;

  // Behavioural buffers: header FIFO (FWFT) and word store returning data 1 cycle after rdreq.
  logic [HW-1:0] hdr_mem [N][DEPTH];
  logic [DW-1:0] wrd_mem [N][DEPTH];
  int unsigned   hdr_wr [N], hdr_rd [N], wrd_wr [N], wrd_rd [N];
  logic [DW-1:0] wvb_q [N];

  for (genvar c = 0; c < N; c++) begin : g_buf
    assign hdr_empty[c]          = (hdr_wr[c] == hdr_rd[c]);
    assign hdr_data[c*HW +: HW]  = hdr_mem[c][hdr_rd[c] % DEPTH];
    assign wvb_data[c*DW +: DW]  = wvb_q[c];
  end

  always @(posedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (flush) begin
        hdr_rd[c] <= hdr_wr[c];
        wrd_rd[c] <= wrd_wr[c];
      end else begin
        if (hdr_rdreq[c]) hdr_rd[c] <= hdr_rd[c] + 1;
        if (wvb_rdreq[c]) begin
          wvb_q[c]  <= wrd_mem[c][wrd_rd[c] % DEPTH];
          wrd_rd[c] <= wrd_rd[c] + 1;
        end
      end
    end
  end

  int unsigned   gn = 0, an = 0, dn = 0, rqn = 0;
  logic [N-1:0]  g_log [256];
  logic [N-1:0]  d_log [256];
  logic [DW-1:0] a_data [512];
  logic          a_sop [512];
  logic          a_eop [512];
  logic [HW-1:0] a_hdr [512];

  always @(negedge clk) begin
    if (hdr_rdreq != '0) begin
      g_log[gn % 256] <= hdr_rdreq;
      gn <= gn + 1;
    end
    if (wvb_rddone != '0) begin
      d_log[dn % 256] <= wvb_rddone;
      dn <= dn + 1;
    end
    if (wvb_rdreq != '0) rqn <= rqn + 1;
    if (out_if.valid && out_if.ready) begin
      a_data[an % 512] <= out_if.data;
      a_sop[an % 512]  <= out_if.sop;
      a_eop[an % 512]  <= out_if.eop;
      a_hdr[an % 512]  <= out_if.hdr;
      an <= an + 1;
    end
  end

  int total = 0;
  int bad   = 0;

  function automatic logic [DW-1:0] mk_word(input int c, input int tag, input int i,
                                            input bit eoe);
    return {eoe, 2'(c), 8'(tag), 11'(i)};
  endfunction

  function automatic logic [HW-1:0] mk_hdr(input int c, input int tag);
    return {16'hC0DE, 8'(c), 8'(tag), 48'h0123_4567_89AB};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_event(input int c, input int tag, input int n, input bit eoe_last);
    for (int i = 0; i < n; i++) begin
      wrd_mem[c][wrd_wr[c] % DEPTH] = mk_word(c, tag, i, eoe_last && (i == n - 1));
      wrd_wr[c] = wrd_wr[c] + 1;
    end
    hdr_mem[c][hdr_wr[c] % DEPTH] = mk_hdr(c, tag);
    hdr_wr[c] = hdr_wr[c] + 1;
  endtask

  task automatic wait_quiet(input string name);
    int q = 0;
    int n = 0;
    tick(2);
    while (q < 4 && n < 400) begin
      tick(1);
      n++;
      if (busy) q = 0;
      else q++;
    end
    total++;
    if (q < 4) begin
      bad++;
      $display("FAIL %s_quiet: busy=%0b still after %0d cycles, want idle", name, busy, n);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b1;
    tick(2);
    flush = 1'b0;
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    int g0;
    int n = 0;
    rst_n = 1'b0; en = 1'b1; chan_mask = 4'hF; out_if.ready = 1'b1; flush = 1'b0;
    for (int c = 0; c < N; c++) load_event(c, 8'h01, 1, 1'b1);
    tick(3);
    total++;
    if ({hdr_rdreq, wvb_rdreq, wvb_rddone} !== 12'h000) begin
      bad++;
      $display("FAIL reset_strobes: got %h want 000", {hdr_rdreq, wvb_rdreq, wvb_rddone});
    end
    total++;
    if ({out_if.valid, out_if.sop, out_if.eop, err_overlen, busy} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 00000",
               {out_if.valid, out_if.sop, out_if.eop, err_overlen, busy});
    end
    total++;
    if ({out_if.data, out_if.hdr, out_if.chan} !== '0) begin
      bad++;
      $display("FAIL reset_bus: data=%h hdr=%h chan=%0d want 0", out_if.data, out_if.hdr,
               out_if.chan);
    end
    g0 = gn;
    rst_n = 1'b1;
    while (hdr_rdreq == '0 && n < 20) begin
      tick(1);
      n++;
    end
    total++;
    if (hdr_rdreq !== 4'b0001) begin
      bad++;
      $display("FAIL reset_first_grant: got %b want 0001", hdr_rdreq);
    end
    wait_quiet("reset");
    for (int i = 0; i < 4; i++) begin
      total++;
      if (g_log[(g0 + i) % 256] !== 4'(1 << i)) begin
        bad++;
        $display("FAIL reset_order%0d: got %b want %b", i, g_log[(g0 + i) % 256], 4'(1 << i));
      end
    end
  endtask

  task automatic test_single();
    int a0 = an;
    int d0 = dn;
    int n = 0;
    load_event(2, 8'h10, 3, 1'b1);
    while (hdr_rdreq == '0 && n < 20) begin
      tick(1);
      n++;
    end
    total++;
    if (hdr_rdreq !== 4'b0100) begin
      bad++;
      $display("FAIL single_hdr_rdreq: got %b want 0100", hdr_rdreq);
    end
    tick(1);
    total++;
    if (wvb_rdreq !== 4'b0100) begin
      bad++;
      $display("FAIL single_rdreq_t1: got %b want 0100", wvb_rdreq);
    end
    tick(1);
    total++;
    if (out_if.valid !== 1'b0) begin
      bad++;
      $display("FAIL single_valid_t2: got %b want 0", out_if.valid);
    end
    tick(1);
    total++;
    if ({out_if.valid, out_if.sop, out_if.chan} !== {1'b1, 1'b1, 2'd2}) begin
      bad++;
      $display("FAIL single_t3: valid=%b sop=%b chan=%0d want 1 1 2", out_if.valid, out_if.sop,
               out_if.chan);
    end
    total++;
    if (out_if.hdr !== mk_hdr(2, 8'h10)) begin
      bad++;
      $display("FAIL single_hdr: got %h want %h", out_if.hdr, mk_hdr(2, 8'h10));
    end
    wait_quiet("single");
    total++;
    if (an - a0 !== 3) begin
      bad++;
      $display("FAIL single_count: got %0d words want 3", an - a0);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({a_data[(a0 + i) % 512], a_sop[(a0 + i) % 512], a_eop[(a0 + i) % 512]} !==
          {mk_word(2, 8'h10, i, i == 2), i == 0, i == 2}) begin
        bad++;
        $display("FAIL single_word%0d: got %h sop=%b eop=%b want %h", i, a_data[(a0 + i) % 512],
                 a_sop[(a0 + i) % 512], a_eop[(a0 + i) % 512], mk_word(2, 8'h10, i, i == 2));
      end
    end
    total++;
    if (dn - d0 !== 1 || d_log[d0 % 256] !== 4'b0100) begin
      bad++;
      $display("FAIL single_rddone: got %0d pulses last=%b want 1 x 0100", dn - d0,
               d_log[d0 % 256]);
    end
  endtask

  task automatic test_round_robin();
    int g0, a0;
    int order_m [4] = '{1, 3, 1, 3};
    int order_r [4] = '{0, 2, 0, 2};
    do_reset();
    g0 = gn;
    a0 = an;
    for (int e = 0; e < 2; e++)
      for (int c = 0; c < N; c++) load_event(c, 8'h20 + e, 2, 1'b1);
    wait_quiet("rr");
    for (int i = 0; i < 8; i++) begin
      total++;
      if (g_log[(g0 + i) % 256] !== 4'(1 << (i % 4))) begin
        bad++;
        $display("FAIL rr_grant%0d: got %b want %b", i, g_log[(g0 + i) % 256], 4'(1 << (i % 4)));
      end
      total++;
      if (a_data[(a0 + 2 * i + 1) % 512] !== mk_word(i % 4, 8'h20 + i / 4, 1, 1'b1)) begin
        bad++;
        $display("FAIL rr_word%0d: got %h want %h", i, a_data[(a0 + 2 * i + 1) % 512],
                 mk_word(i % 4, 8'h20 + i / 4, 1, 1'b1));
      end
    end
    chan_mask = 4'b1010;
    g0 = gn;
    for (int e = 0; e < 2; e++)
      for (int c = 0; c < N; c++) load_event(c, 8'h30 + e, 1, 1'b1);
    wait_quiet("rr_mask");
    total++;
    if (gn - g0 !== 4) begin
      bad++;
      $display("FAIL rr_mask_count: got %0d grants want 4", gn - g0);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (g_log[(g0 + i) % 256] !== 4'(1 << order_m[i])) begin
        bad++;
        $display("FAIL rr_mask%0d: got %b want %b", i, g_log[(g0 + i) % 256],
                 4'(1 << order_m[i]));
      end
    end
    chan_mask = 4'hF;
    g0 = gn;
    wait_quiet("rr_unmask");
    for (int i = 0; i < 4; i++) begin
      total++;
      if (g_log[(g0 + i) % 256] !== 4'(1 << order_r[i])) begin
        bad++;
        $display("FAIL rr_unmask%0d: got %b want %b", i, g_log[(g0 + i) % 256],
                 4'(1 << order_r[i]));
      end
    end
  endtask

  task automatic test_backpressure();
    int a0 = an;
    int r0 = rqn;
    int n = 0;
    int stable_bad = 0;
    int rq;
    logic [DW-1:0] d;
    logic [HW-1:0] h;
    out_if.ready = 1'b1;
    load_event(1, 8'h40, 5, 1'b1);
    while (an - a0 < 2 && n < 50) begin
      tick(1);
      n++;
    end
    out_if.ready = 1'b0;
    n = 0;
    while (!out_if.valid && n < 10) begin
      tick(1);
      n++;
    end
    d = out_if.data;
    h = out_if.hdr;
    rq = rqn;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (out_if.data !== d || out_if.hdr !== h || out_if.valid !== 1'b1) stable_bad++;
    end
    total++;
    if (stable_bad !== 0 || d !== mk_word(1, 8'h40, 2, 1'b0)) begin
      bad++;
      $display("FAIL bp_stable: %0d unstable cycles, held %h want %h", stable_bad, d,
               mk_word(1, 8'h40, 2, 1'b0));
    end
    total++;
    if (rqn - rq !== 0) begin
      bad++;
      $display("FAIL bp_no_read: got %0d reads while stalled want 0", rqn - rq);
    end
    out_if.ready = 1'b1;
    wait_quiet("bp");
    total++;
    if (an - a0 !== 5 || rqn - r0 !== 5) begin
      bad++;
      $display("FAIL bp_counts: words=%0d reads=%0d want 5 5", an - a0, rqn - r0);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (a_data[(a0 + i) % 512] !== mk_word(1, 8'h40, i, i == 4)) begin
        bad++;
        $display("FAIL bp_word%0d: got %h want %h", i, a_data[(a0 + i) % 512],
                 mk_word(1, 8'h40, i, i == 4));
      end
    end
  endtask

  task automatic test_overlen();
    int a0, d0;
    do_reset();
    a0 = an;
    load_event(0, 8'h50, 8, 1'b1);
    wait_quiet("ovl_exact");
    total++;
    if ({an - a0 == 8, a_eop[(a0 + 6) % 512], a_eop[(a0 + 7) % 512], err_overlen} !== 4'b1010)
    begin
      bad++;
      $display("FAIL ovl_exact: words=%0d eop6=%b eop7=%b err=%b want 8 0 1 0", an - a0,
               a_eop[(a0 + 6) % 512], a_eop[(a0 + 7) % 512], err_overlen);
    end
    a0 = an;
    d0 = dn;
    load_event(0, 8'h51, 8, 1'b0);
    load_event(0, 8'h52, 2, 1'b1);
    wait_quiet("ovl");
    total++;
    if (an - a0 !== 10) begin
      bad++;
      $display("FAIL ovl_count: got %0d words want 10", an - a0);
    end
    total++;
    if ({a_data[(a0 + 7) % 512], a_eop[(a0 + 7) % 512], a_eop[(a0 + 6) % 512]} !==
        {mk_word(0, 8'h51, 7, 1'b0), 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL ovl_word8: got %h eop=%b want %h eop=1", a_data[(a0 + 7) % 512],
               a_eop[(a0 + 7) % 512], mk_word(0, 8'h51, 7, 1'b0));
    end
    total++;
    if (dn - d0 !== 2 || d_log[d0 % 256] !== 4'b0001) begin
      bad++;
      $display("FAIL ovl_rddone: got %0d pulses first=%b want 2 x 0001", dn - d0,
               d_log[d0 % 256]);
    end
    total++;
    if ({a_data[(a0 + 9) % 512], a_sop[(a0 + 8) % 512], a_eop[(a0 + 9) % 512],
         a_hdr[(a0 + 8) % 512]} !== {mk_word(0, 8'h52, 1, 1'b1), 1'b1, 1'b1, mk_hdr(0, 8'h52)})
    begin
      bad++;
      $display("FAIL ovl_next_event: got %h sop=%b eop=%b want %h", a_data[(a0 + 9) % 512],
               a_sop[(a0 + 8) % 512], a_eop[(a0 + 9) % 512], mk_word(0, 8'h52, 1, 1'b1));
    end
    tick(5);
    total++;
    if (err_overlen !== 1'b1) begin
      bad++;
      $display("FAIL ovl_sticky: got %b want 1", err_overlen);
    end
  endtask

  task automatic test_en_mid();
    int g0 = gn;
    int a0 = an;
    int d0 = dn;
    int n = 0;
    en = 1'b1;
    load_event(3, 8'h60, 6, 1'b1);
    while (hdr_rdreq == '0 && n < 20) begin
      tick(1);
      n++;
    end
    en = 1'b0;
    load_event(1, 8'h61, 1, 1'b1);
    wait_quiet("en_mid");
    total++;
    if (gn - g0 !== 1 || an - a0 !== 6) begin
      bad++;
      $display("FAIL en_mid_hold: grants=%0d words=%0d want 1 6", gn - g0, an - a0);
    end
    total++;
    if (dn - d0 !== 1 || d_log[d0 % 256] !== 4'b1000) begin
      bad++;
      $display("FAIL en_mid_rddone: got %0d pulses first=%b want 1 x 1000", dn - d0,
               d_log[d0 % 256]);
    end
    en = 1'b1;
    wait_quiet("en_resume");
    total++;
    if (gn - g0 !== 2 || g_log[(g0 + 1) % 256] !== 4'b0010) begin
      bad++;
      $display("FAIL en_resume: grants=%0d second=%b want 2 0010", gn - g0,
               g_log[(g0 + 1) % 256]);
    end
  endtask

  task automatic test_reset_mid();
    int a0 = an;
    int d0 = dn;
    int n = 0;
    load_event(2, 8'h70, 6, 1'b1);
    while (an - a0 < 1 && n < 30) begin
      tick(1);
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_if.valid, out_if.sop, out_if.eop, busy, err_overlen, hdr_rdreq, wvb_rdreq,
         wvb_rddone} !== 17'b0) begin
      bad++;
      $display("FAIL rst_mid_async: valid=%b busy=%b err=%b strobes=%h want all 0",
               out_if.valid, busy, err_overlen, {hdr_rdreq, wvb_rdreq, wvb_rddone});
    end
    flush = 1'b1;
    tick(2);
    rst_n = 1'b1;
    flush = 1'b0;
    tick(5);
    total++;
    if (dn - d0 !== 0 || an - a0 !== 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_abort: rddone=%0d words=%0d busy=%b want 0 1 0", dn - d0,
               an - a0, busy);
    end
    load_event(2, 8'h71, 1, 1'b1);
    wait_quiet("rst_recover");
    total++;
    if (dn - d0 !== 1 || a_data[(a0 + 1) % 512] !== mk_word(2, 8'h71, 0, 1'b1)) begin
      bad++;
      $display("FAIL rst_recover: rddone=%0d word=%h want 1 %h", dn - d0,
               a_data[(a0 + 1) % 512], mk_word(2, 8'h71, 0, 1'b1));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overlen();
    test_en_mid();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
